// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
// UART_RX_PARITY_EN adds the PARITY state to the receiver encoding.
package uart_pkg;

  localparam int UART_CLK_HZ_DEFAULT = 25_000_000;
  localparam int UART_BAUD_DEFAULT   = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY    = 3'd3,
`endif
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - reloadable down-counter with a one-cycle expiry tick
module uart_bit_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  // Tick fires when the count reaches 1, so a load of N yields a tick N cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8-bit UART receiver, 8N1 by default
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = UART_CLK_HZ_DEFAULT,
  parameter int BAUD   = UART_BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT);

  uart_rx_state_t   r_state;
  uart_rx_state_t   w_next_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic             r_framing_error;
  logic             w_par_err;

  // Synchronizer flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  uart_bit_timer #(
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = FULL_RELOAD;
    case (r_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_next_state = RX_START;
          w_load       = 1'b1;
          w_load_val   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (w_rx) begin
            w_next_state = RX_IDLE;
          end else begin
            w_next_state = RX_DATA;
            w_load       = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          w_load = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_next_state = RX_PARITY;
`else
            w_next_state = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (w_tick) begin
          w_load       = 1'b1;
          w_next_state = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // A good stop sample returns straight to IDLE so a back-to-back start is caught.
        if (w_tick) begin
          w_next_state = w_rx ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx) begin
          w_next_state = RX_IDLE;
        end
      end
      default: w_next_state = RX_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit      <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_parity_error <= 1'b0;
      if (r_state == RX_PARITY && w_tick) begin
        r_par_bit <= w_rx;
      end
      if (r_state == RX_STOP && w_tick && w_rx && w_par_err) begin
        r_parity_error <= 1'b1;
      end
    end
  end

  assign w_par_err    = (^r_shift) ^ r_par_bit;
  assign parity_error = r_parity_error;
`else
  assign w_par_err    = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift         <= 8'h00;
      r_bit_idx       <= 3'd0;
      r_data          <= 8'h00;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      if (r_state == RX_START) begin
        r_bit_idx <= 3'd0;
      end
      if (r_state == RX_DATA && w_tick) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (r_state == RX_STOP && w_tick) begin
        if (!w_rx) begin
          r_framing_error <= 1'b1;
        end else if (!w_par_err) begin
          r_data       <= r_shift;
          r_data_valid <= 1'b1;
        end
      end
    end
  end

  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver at default 217 clk/bit
module tb_uart_receiver;

  localparam int CPB = 217;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2064 + CPB;
`else
  localparam int LAT = 2064;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;

  uart_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  // kind is {parity_error, framing_error, data_valid}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    logic       chk_lat;
    time        t0;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [2:0] mon_got;
  exp_t       mon_e;
  int         mon_lat;

  always @(negedge clk) begin
    mon_got = {parity_error, framing_error, data_valid};
    if (mon_got != 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got kind=%b data=%02h required no pulse", mon_got, data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got != mon_e.kind || data !== mon_e.data) begin
          bad++;
          $display("FAIL event: got kind=%b data=%02h required kind=%b data=%02h",
                   mon_got, data, mon_e.kind, mon_e.data);
        end
        if (mon_e.chk_lat) begin
          total++;
          mon_lat = int'(($time - mon_e.t0) / 10);
          if (mon_lat < LAT - 2 || mon_lat > LAT + 3) begin
            bad++;
            $display("FAIL latency: got %0d cycles required %0d..%0d", mon_lat, LAT - 2, LAT + 3);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%02h required=%02h", name, act, req);
    end
  endtask

  task automatic check_quiet_outputs(input string name, input logic [7:0] req_data);
    check({name, "_data"}, data, req_data);
    check({name, "_dv"}, {7'd0, data_valid}, 8'h00);
    check({name, "_fe"}, {7'd0, framing_error}, 8'h00);
    check({name, "_pe"}, {7'd0, parity_error}, 8'h00);
  endtask

  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input logic [2:0] kind, input logic [7:0] d, input logic chk);
    exp_t e;
    e.kind    = kind;
    e.data    = d;
    e.chk_lat = chk;
    e.t0      = $time;
    exp_q.push_back(e);
  endtask

  task automatic send_head(input logic [7:0] d);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold_line(^d, CPB);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    hold_line(1'b1, CPB);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check_quiet_outputs("reset", 8'h00);
    rst = 1'b0;
    hold_line(1'b1, 20);

    expect_event(3'b001, 8'h55, 1'b1);
    send_frame(8'h55);
    wait_drain("rx_55");
    hold_line(1'b1, 300);

    hold_line(1'b0, 50);
    hold_line(1'b1, 400);
    check_quiet_outputs("glitch", 8'h55);
    expect_event(3'b001, 8'hC3, 1'b0);
    send_frame(8'hC3);
    wait_drain("after_glitch");
    hold_line(1'b1, 300);

    expect_event(3'b010, 8'hC3, 1'b0);
    send_head(8'h00);
    hold_line(1'b0, 2000);
    wait_drain("framing");
    hold_line(1'b1, 600);

    expect_event(3'b001, 8'h48, 1'b0);
    expect_event(3'b001, 8'h65, 1'b0);
    send_frame(8'h48);
    send_frame(8'h65);
    wait_drain("back_to_back");
    hold_line(1'b1, 300);

    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(i[0] ? 1'b0 : 1'b1, CPB);
    hold_line(1'b0, 100);
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet_outputs("mid_reset", 8'h00);
    rst = 1'b0;
    hold_line(1'b1, 400);
    expect_event(3'b001, 8'h3C, 1'b0);
    send_frame(8'h3C);
    wait_drain("after_reset");
    hold_line(1'b1, 300);

`ifdef UART_RX_PARITY_EN
    expect_event(3'b100, 8'h3C, 1'b0);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(((8'hA5 >> i) & 8'h01) != 8'h00, CPB);
    hold_line(1'b1, CPB);
    hold_line(1'b1, CPB);
    wait_drain("parity");
    hold_line(1'b1, 300);
`endif

    hold_line(1'b1, 500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
